// File: rtl/wb_arbiter.sv
// Writeback arbiter for the GPR write port: merges pipeline results (fixed priority) with a
// FIFO of long-latency results and tracks pending destinations. Optional macro: WB_STATS_EN.
module wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        pipe_we,
  input  logic [RFIDX_WIDTH-1:0]      pipe_wa,
  input  logic [XLEN-1:0]             pipe_wd,
  input  logic                        lu_valid,
  output logic                        lu_ready,
  input  logic [RFIDX_WIDTH-1:0]      lu_wa,
  input  logic [XLEN-1:0]             lu_wd,
  input  logic                        issue_valid,
  input  logic [RFIDX_WIDTH-1:0]      issue_rd,
  output logic [2**RFIDX_WIDTH-1:0]   busy_mask,
  output logic                        hazard_err,
  output logic                        we3,
  output logic [RFIDX_WIDTH-1:0]      wa3,
  output logic [XLEN-1:0]             wd3
`ifdef WB_STATS_EN
  ,
  output logic [31:0]                 drain_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NREG  = 2**RFIDX_WIDTH;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [RFIDX_WIDTH-1:0] r_fifo_wa [FIFO_DEPTH];
  logic [XLEN-1:0]        r_fifo_wd [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_head, r_tail;
  logic [PTR_W:0]         r_count;

  logic                   w_empty, w_push, w_pop, w_pipe_win, w_pop_wr;
  logic [RFIDX_WIDTH-1:0] w_head_wa;
  logic [XLEN-1:0]        w_head_wd;
  logic [NREG-1:0]        w_busy_nxt;

  assign w_empty    = (r_count == '0);
  assign lu_ready   = (r_count != FULL_CNT);
  assign w_push     = lu_valid && lu_ready;
  // A pipeline write to x0 is no request, so the FIFO may drain that cycle.
  assign w_pipe_win = pipe_we && (pipe_wa != '0);
  assign w_pop      = !w_pipe_win && !w_empty;
  assign w_head_wa  = r_fifo_wa[r_head];
  assign w_head_wd  = r_fifo_wd[r_head];
  assign w_pop_wr   = w_pop && (w_head_wa != '0);

  // NOTE: FIFO storage has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wa[r_tail] <= lu_wa;
      r_fifo_wd[r_tail] <= lu_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    w_busy_nxt = busy_mask;
    if (w_pop_wr) w_busy_nxt[w_head_wa] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_mask  <= '0;
      hazard_err <= 1'b0;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
    end else begin
      busy_mask  <= w_busy_nxt;
      hazard_err <= hazard_err | (w_pipe_win && busy_mask[pipe_wa]);
      we3        <= w_pipe_win || w_pop_wr;
      if (w_pipe_win) begin
        wa3 <= pipe_wa;
        wd3 <= pipe_wd;
      end else if (w_pop_wr) begin
        wa3 <= w_head_wa;
        wd3 <= w_head_wd;
      end
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_stall_cnt <= '0;
    end else if (w_pipe_win && !w_empty && (drain_stall_cnt != 32'hFFFF_FFFF)) begin
      drain_stall_cnt <= drain_stall_cnt + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always @(negedge clk) begin
    if (rstn && we3) $display("wb x%0d = %h", wa3, wd3);
  end
`endif
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, random traffic against a
// queue-based reference model, and an asynchronous reset in mid-operation.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic            pipe_we, lu_valid, issue_valid;
  logic [RW-1:0]   pipe_wa, lu_wa, issue_rd;
  logic [XLEN-1:0] pipe_wd, lu_wd;
  logic            lu_ready, hazard_err, we3;
  logic [31:0]     busy_mask;
  logic [RW-1:0]   wa3;
  logic [XLEN-1:0] wd3;
`ifdef WB_STATS_EN
  logic [31:0]     drain_stall_cnt;
`endif

  wb_arbiter #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_mask(busy_mask), .hazard_err(hazard_err),
    .we3(we3), .wa3(wa3), .wd3(wd3)
`ifdef WB_STATS_EN
    , .drain_stall_cnt(drain_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending results are a plain queue, pending registers a bit set.
  typedef struct { logic [RW-1:0] wa; logic [XLEN-1:0] wd; } ent_t;
  ent_t            m_q[$];
  logic [31:0]     m_busy;
  logic            m_haz, m_we3;
  logic [RW-1:0]   m_wa3;
  logic [XLEN-1:0] m_wd3;

  task automatic model_reset();
    m_q.delete();
    m_busy = '0; m_haz = 1'b0; m_we3 = 1'b0; m_wa3 = '0; m_wd3 = '0;
  endtask

  task automatic model_step();
    bit   ready, pipe_win, pop;
    ent_t head, ne;
    ready    = (m_q.size() < DEPTH);
    pipe_win = pipe_we && (pipe_wa != 0);
    pop      = !pipe_win && (m_q.size() > 0);
    if (pipe_win && m_busy[pipe_wa]) m_haz = 1'b1;
    m_we3 = 1'b0;
    if (pipe_win) begin
      m_we3 = 1'b1; m_wa3 = pipe_wa; m_wd3 = pipe_wd;
    end else if (pop) begin
      head = m_q.pop_front();
      if (head.wa != 0) begin
        m_we3 = 1'b1; m_wa3 = head.wa; m_wd3 = head.wd;
        m_busy[head.wa] = 1'b0;
      end
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (lu_valid && ready) begin
      ne.wa = lu_wa; ne.wd = lu_wd;
      m_q.push_back(ne);
    end
  endtask

  // One clock: check lu_ready before the edge, then all registered outputs after it.
  task automatic cycle(input string tag);
    check({tag, " lu_ready"}, {31'b0, lu_ready}, {31'b0, (m_q.size() < DEPTH)});
    model_step();
    @(posedge clk);
    #1;
    check({tag, " we3"},        {31'b0, we3},        {31'b0, m_we3});
    check({tag, " wa3"},        {27'b0, wa3},        {27'b0, m_wa3});
    check({tag, " wd3"},        wd3,                 m_wd3);
    check({tag, " busy_mask"},  busy_mask,           m_busy);
    check({tag, " hazard_err"}, {31'b0, hazard_err}, {31'b0, m_haz});
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
    lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  typedef struct {
    logic pwe; logic [RW-1:0] pwa; logic [31:0] pwd;
    logic lv;  logic [RW-1:0] lwa; logic [31:0] lwd;
    logic iv;  logic [RW-1:0] ird;
    logic e_ready; logic e_we3; logic [RW-1:0] e_wa3; logic [31:0] e_wd3;
    logic [31:0] e_busy; logic e_haz;
  } vec_t;

  function automatic vec_t mkv(
    input logic pwe, input logic [RW-1:0] pwa, input logic [31:0] pwd,
    input logic lv,  input logic [RW-1:0] lwa, input logic [31:0] lwd,
    input logic iv,  input logic [RW-1:0] ird,
    input logic e_ready, input logic e_we3, input logic [RW-1:0] e_wa3,
    input logic [31:0] e_wd3, input logic [31:0] e_busy, input logic e_haz);
    vec_t v;
    v.pwe = pwe; v.pwa = pwa; v.pwd = pwd; v.lv = lv; v.lwa = lwa; v.lwd = lwd;
    v.iv = iv; v.ird = ird; v.e_ready = e_ready; v.e_we3 = e_we3; v.e_wa3 = e_wa3;
    v.e_wd3 = e_wd3; v.e_busy = e_busy; v.e_haz = e_haz;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    //                 pwe   pwa    pwd            lv    lwa    lwd      iv    ird    rdy   we3   wa3    wd3            busy          haz
    vecs.push_back(mkv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,        1'b0)); // pipe only
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mkv(1'b1, 5'd7, 32'h77,       1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h77,       32'h0,        1'b0)); // fill
    vecs.push_back(mkv(1'b1, 5'd7, 32'h77,       1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h77,       32'h0,        1'b0));
    vecs.push_back(mkv(1'b1, 5'd7, 32'h77,       1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h77,       32'h0,        1'b0)); // full
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 32'h11,       32'h0,        1'b0)); // pop while full
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 1'b1, 5'd2, 32'h22,       32'h0,        1'b0)); // push+pop
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h33,       32'h0,        1'b0));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd3, 32'h33,       32'h0,        1'b0));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 32'h33,       32'h200,      1'b0)); // scoreboard
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1, 1'b0, 5'd3, 32'h33,       32'h200,      1'b0));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd9, 32'h99,       32'h0,        1'b0)); // clear on pop
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h98, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 32'h99,       32'h200,      1'b0));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 32'h98,       32'h200,      1'b0)); // set wins
    vecs.push_back(mkv(1'b1, 5'd8, 32'h88,       1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8, 32'h88,       32'h200,      1'b0)); // x0 handling
    vecs.push_back(mkv(1'b1, 5'd0, 32'hBAD,      1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 1'b1, 1'b1, 5'd4, 32'h44,       32'h200,      1'b0));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b1, 1'b0, 5'd4, 32'h44,       32'h200,      1'b0));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd4, 32'h44,       32'h200,      1'b0)); // wa=0 pop
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 32'h44,       32'h240,      1'b0)); // WAW
    vecs.push_back(mkv(1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd6, 32'h66,       32'h240,      1'b1));
    vecs.push_back(mkv(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd6, 32'h66,       32'h240,      1'b1));

    idle_inputs();
    model_reset();
    rstn = 1'b0;
    #12;
    check("reset we3",        {31'b0, we3},        32'h0);
    check("reset wa3",        {27'b0, wa3},        32'h0);
    check("reset wd3",        wd3,                 32'h0);
    check("reset busy_mask",  busy_mask,           32'h0);
    check("reset hazard_err", {31'b0, hazard_err}, 32'h0);
    check("reset lu_ready",   {31'b0, lu_ready},   32'h1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      pipe_we = vecs[i].pwe; pipe_wa = vecs[i].pwa; pipe_wd = vecs[i].pwd;
      lu_valid = vecs[i].lv; lu_wa = vecs[i].lwa; lu_wd = vecs[i].lwd;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      #1;
      check({tag, " tbl lu_ready"}, {31'b0, lu_ready}, {31'b0, vecs[i].e_ready});
      cycle(tag);
      check({tag, " tbl we3"},        {31'b0, we3},        {31'b0, vecs[i].e_we3});
      check({tag, " tbl wa3"},        {27'b0, wa3},        {27'b0, vecs[i].e_wa3});
      check({tag, " tbl wd3"},        wd3,                 vecs[i].e_wd3);
      check({tag, " tbl busy_mask"},  busy_mask,           vecs[i].e_busy);
      check({tag, " tbl hazard_err"}, {31'b0, hazard_err}, {31'b0, vecs[i].e_haz});
    end

    for (int n = 0; n < 2000; n++) begin
      pipe_we     = ($urandom_range(0, 1) == 1);
      pipe_wa     = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom);
      pipe_wd     = $urandom;
      lu_valid    = ($urandom_range(0, 1) == 1);
      lu_wa       = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom);
      lu_wd       = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom);
      #1;
      cycle($sformatf("rnd%0d", n));
    end

    // Async reset with two entries queued, a write in flight and registers pending.
    idle_inputs();
    #1;
    cycle("pre_rst_idle");
    for (int k = 0; k < 2; k++) begin
      pipe_we = 1'b1; pipe_wa = 5'd10; pipe_wd = 32'hA0 + 32'(k);
      lu_valid = 1'b1; lu_wa = 5'd11 + 5'(k); lu_wd = 32'hB0 + 32'(k);
      issue_valid = 1'b1; issue_rd = 5'd11 + 5'(k);
      #1;
      cycle($sformatf("pre_rst%0d", k));
    end
    idle_inputs();
    pipe_we = 1'b1; pipe_wa = 5'd10; pipe_wd = 32'hA5;
    #2;
    rstn = 1'b0;
    #1;
    check("async we3",        {31'b0, we3},        32'h0);
    check("async lu_ready",   {31'b0, lu_ready},   32'h1);
    check("async busy_mask",  busy_mask,           32'h0);
    check("async hazard_err", {31'b0, hazard_err}, 32'h0);
    idle_inputs();
    model_reset();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      cycle($sformatf("post_rst%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
